// File: rtl/seq_mult_mac.sv
// seq_mult_mac: shift-add multiplier, signed/unsigned, valid/ready, optional accumulate with sticky overflow
module seq_mult_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   signed_mode,
  input  logic                   accumulate,
  input  logic                   clear_acc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   overflow,
  output logic                   busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       mag_a_q, mag_a_d;
  logic [2*WIDTH-1:0]     p_q, p_d;
  logic                   neg_q, neg_d, sgn_q, sgn_d, accum_q, accum_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   accept, last, ovf_now;
  logic [WIDTH-1:0]       mag_a_in, mag_b_in;
  logic [WIDTH:0]         sum_hi;
  logic [2*WIDTH-1:0]     p_step, fin;
  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH:0]     acc_sum;
  // Datapath: magnitude capture, one add-and-shift step per RUN cycle, sign fix-up and accumulator add
  always_comb begin
    mag_a_in = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b_in = (signed_mode && b[WIDTH-1]) ? -b : b;
    sum_hi   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_a_q} : '0);
    p_step   = {sum_hi, p_q[WIDTH-1:1]};
    fin      = neg_q ? -p_step : p_step;
    ext      = sgn_q ? ACC_WIDTH'($signed(fin)) : ACC_WIDTH'(fin);
    acc_sum  = {1'b0, acc_q} + {1'b0, ext};
    ovf_now  = sgn_q ? (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])
                     : acc_sum[ACC_WIDTH];
  end
  // Next-state: handshake sequencing, counter, operand latch and result/accumulator update
  always_comb begin
    accept    = (state_q == IDLE) && in_valid;
    last      = (state_q == RUN) && (cnt_q == CW'(WIDTH-1));
    state_d   = accept ? RUN : last ? DONE : (state_q == DONE && out_ready) ? IDLE : state_q;
    cnt_d     = accept ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
    mag_a_d   = accept ? mag_a_in : mag_a_q;
    p_d       = accept ? {{WIDTH{1'b0}}, mag_b_in} : (state_q == RUN) ? p_step : p_q;
    neg_d     = accept ? signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]) : neg_q;
    sgn_d     = accept ? signed_mode : sgn_q;
    accum_d   = accept ? accumulate : accum_q;
    product_d = last ? fin : product_q;
    acc_d     = clear_acc ? '0 : (last && accum_q) ? acc_sum[ACC_WIDTH-1:0] : acc_q;
    ovf_d     = clear_acc ? 1'b0 : (last && accum_q) ? (ovf_q | ovf_now) : ovf_q;
  end
  // State registers with asynchronous reset to an empty, idle block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_a_q   <= '0;
      p_q       <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      accum_q   <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_a_q   <= mag_a_d;
      p_q       <= p_d;
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
      accum_q   <= accum_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign product   = product_q;
  assign acc       = acc_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/seq_mult_mac.md
# seq_mult_mac

Parametrised successor to the 8×8 combinational array multiplier. It is a sequential shift-add multiplier of generic width with signed/unsigned mode, a valid/ready handshake on both sides, and an optional accumulate-into-register mode with sticky overflow. It sits between the top-level IO wrapper and the pin muxing, and trades one cycle per operand bit for a much smaller area than the full array.

## Interface
- `WIDTH`, default 8: operand width, must be ≥ 2.
- `ACC_WIDTH`, default `2*WIDTH+4`: accumulator width, must be ≥ `2*WIDTH`.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operand and mode fields are valid.
- `in_ready` out 1: the block accepts a new operation; equals (state == IDLE).
- `a`, `b` in WIDTH: operands.
- `signed_mode` in 1: 1 = two's-complement operands, 0 = unsigned.
- `accumulate` in 1: 1 = add the product into `acc` on completion.
- `clear_acc` in 1: synchronous clear of `acc` and `overflow`; sampled in every state.
- `out_valid` out 1: `product` is valid; equals (state == DONE).
- `out_ready` in 1: the consumer takes the result.
- `product` out 2*WIDTH: result of the last completed operation, held until the next completion.
- `acc` out ACC_WIDTH: accumulator register.
- `overflow` out 1: sticky flag for accumulator overflow.
- `busy` out 1: equals (state == RUN).

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE → RUN when `in_valid` and `in_ready` are both high at a clock edge.
  - `a`, `b`, `signed_mode` and `accumulate` are latched on that edge.
  - The iteration counter is cleared.
- RUN lasts exactly WIDTH cycles and processes one multiplier bit per cycle.
  - Operand inputs are ignored during RUN.
- Arithmetic:
  - Unsigned mode: `product` = a × b, exact in 2*WIDTH bits.
  - Signed mode: the operation works on operand magnitudes, and the result is negated if the operand signs differ. The result is exact in 2*WIDTH bits two's-complement, including (−2^(W−1))².
- RUN → DONE on the WIDTH-th RUN edge. `product` is registered on that same edge, with the sign fix-up applied.
- Accumulate, applied on the same edge if the latched `accumulate` = 1:
  - `acc` ← `acc` + product, with the product extended to ACC_WIDTH (sign-extended in signed mode, zero-extended in unsigned mode). The result wraps modulo 2^ACC_WIDTH.
  - Signed mode: `overflow` is set on signed overflow (operands of the same sign, result of the opposite sign).
  - Unsigned mode: `overflow` is set on carry-out.
  - `overflow` stays set until `clear_acc` or `rst`.
- `clear_acc` has priority: if it is high on the completing edge, `acc` = 0 and `overflow` = 0, and that accumulation is discarded. `product` is still updated.
- DONE → IDLE when `out_ready` is high at the edge. DONE holds otherwise, with `product` stable.
- Asserting `rst` in any state, including mid-RUN:
  - The state goes immediately to IDLE and the in-flight operation is lost.
  - `product`, `acc`, `overflow`, the counter and the latched operands all clear to 0.

## Timing
- Reset values: `in_ready` = 1 (IDLE); `out_valid` = 0, `busy` = 0, `product` = 0, `acc` = 0, `overflow` = 0.
- Inputs are ignored while `rst` is high.
- Latency: accept on edge 0; `out_valid` is high after edge WIDTH (WIDTH cycles).
- Initiation interval: minimum WIDTH+2 cycles (one DONE cycle with `out_ready` = 1, then one IDLE cycle). There is no accept while in DONE.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from any input.
- `acc` and `overflow` change only on a completing edge, on `clear_acc`, or on `rst`.

## Test plan
- Unsigned, WIDTH = 8:
  - a = 0xFF, b = 0xFF → `product` = 0xFE01.
  - `out_valid` rises exactly 8 cycles after accept.
  - `product` is held while `out_ready` = 0 for 5 cycles.
- Signed, WIDTH = 8:
  - 0x80 × 0x80 → 0x4000.
  - 0x80 × 0x01 → 0xFF80.
  - 0xFF × 0x02 → 0xFFFE.
  - 0x00 × 0x9C → 0x0000.
- Signed accumulate with ACC_WIDTH = 20: 32 back-to-back operations of 0x80 × 0x80.
  - After op 31: `acc` = 0x7C000 and `overflow` = 0.
  - After op 32: `acc` = 0x80000 and `overflow` = 1.
  - `overflow` stays 1 through a further non-accumulate operation.
- Unsigned accumulate: 17 operations of 0xFF × 0xFF.
  - After op 16: `acc` = 0xFE010 and `overflow` = 0.
  - After op 17: `acc` = 0x0DE11 and `overflow` = 1.
  - Then `clear_acc` → `acc` = 0 and `overflow` = 0.
- Simultaneous events:
  - `clear_acc` coincides with an accumulating completion → `acc` = 0 and `overflow` = 0, while `product` is still updated.
  - `in_valid` held high while DONE is back-pressured → no second accept until after `out_ready`.
- Reset mid-RUN: pulse `rst` at RUN cycle 3 → immediately IDLE, with `product` = 0, `acc` = 0 and `out_valid` never asserted. The next operation 3 × 5 → 0x000F.
